conware_grid: RTL and testbench

CONWARE_GRID -- requirements
Module: conware_grid

---
 rtl/conware_grid.sv | 270 +++++++++++++++++++++++++++
 tb/tb_conware_grid.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conware_grid.sv
// -----------------------------------------------------------------------------
// conware_grid
//
// Conway's Game of Life engine with AXI-Stream video in and out. A frame of
// WIDTH*HEIGHT pixels (raster order, one pixel per beat) is loaded into the
// cur board. The engine then advances num_gens generations, one board row per
// clock, and streams the result back out as ALIVE_COLOR / DEAD_COLOR pixels.
//
// Optional build macro:
//   CONWARE_TORUS_EN  neighbour rows/columns wrap around (toroidal board).
//                     Undefined: cells outside the board count as dead.
//
// Parameters:
//   DWIDTH       stream data width, one pixel per beat
//   WIDTH        board columns (3..64)
//   HEIGHT       board rows (3..64)
//   ALIVE_COLOR  pixel emitted for a live cell
//   DEAD_COLOR   pixel emitted for a dead cell; any other input pixel is live
//
// Ports:
//   ACLK, ARESET        clock, synchronous active-high reset
//   S_AXIS_*            pixel input stream (TVALID/TREADY/TDATA/TLAST)
//   M_AXIS_*            pixel output stream (TVALID/TREADY/TDATA/TLAST/TKEEP/TSTRB)
//   num_gens            generations per frame, sampled on the last input beat
//   state               0 LOAD, 1 COMPUTE, 2 SEND
//   gen_ctr             generations completed in the current frame
//   frames_done         frames fully sent since reset (wraps)
//   frame_err           sticky: TLAST did not coincide with the last pixel
// -----------------------------------------------------------------------------
module conware_grid #(
    parameter int unsigned       DWIDTH      = 32,
    parameter int unsigned       WIDTH       = 8,
    parameter int unsigned       HEIGHT      = 8,
    parameter logic [DWIDTH-1:0] ALIVE_COLOR = 32'hFFFFFFFF,
    parameter logic [DWIDTH-1:0] DEAD_COLOR  = 32'h00000000
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic [DWIDTH-1:0]     S_AXIS_TDATA,
    input  logic                  S_AXIS_TLAST,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic [DWIDTH-1:0]     M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    output logic [DWIDTH/8-1:0]   M_AXIS_TKEEP,
    output logic [DWIDTH/8-1:0]   M_AXIS_TSTRB,
    input  logic [7:0]            num_gens,
    output logic [1:0]            state,
    output logic [7:0]            gen_ctr,
    output logic [31:0]           frames_done,
    output logic                  frame_err
);

    localparam int unsigned NPIX = WIDTH * HEIGHT;
    localparam int unsigned PW   = $clog2(NPIX);
    localparam int unsigned RW   = $clog2(HEIGHT);

    localparam logic [1:0] StLoad    = 2'd0;
    localparam logic [1:0] StCompute = 2'd1;
    localparam logic [1:0] StSend    = 2'd2;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [1:0]      state_q, state_d;
    logic [NPIX-1:0] cur_q, cur_d;
    logic [NPIX-1:0] nxt_q, nxt_d;
    logic [PW-1:0]   pix_idx_q, pix_idx_d;
    logic [PW-1:0]   out_idx_q, out_idx_d;
    logic [RW-1:0]   row_idx_q, row_idx_d;
    logic [7:0]      gen_ctr_q, gen_ctr_d;
    logic [7:0]      num_gens_q, num_gens_d;
    logic [31:0]     frames_done_q, frames_done_d;
    logic            frame_err_q, frame_err_d;

    // ---------------------------------------------------------------------
    // Handshakes
    // ---------------------------------------------------------------------
    logic s_tready;
    logic m_tvalid;
    logic s_beat;
    logic m_beat;
    logic pix_last;
    logic out_last;

    assign s_tready = (state_q == StLoad) && !ARESET;
    assign m_tvalid = (state_q == StSend);
    assign s_beat   = S_AXIS_TVALID && s_tready;
    assign m_beat   = m_tvalid && M_AXIS_TREADY;
    assign pix_last = (pix_idx_q == PW'(NPIX - 1));
    assign out_last = (out_idx_q == PW'(NPIX - 1));

    // ---------------------------------------------------------------------
    // Row neighbourhood of the row being computed
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] cur_rows [HEIGHT];

    for (genvar gr = 0; gr < HEIGHT; gr++) begin : g_rows
        assign cur_rows[gr] = cur_q[gr*WIDTH +: WIDTH];
    end

    logic             row_first;
    logic             row_last;
    logic [RW-1:0]    row_up_idx;
    logic [RW-1:0]    row_dn_idx;
    logic [WIDTH-1:0] row_up;
    logic [WIDTH-1:0] row_mid;
    logic [WIDTH-1:0] row_dn;

    assign row_first = (row_idx_q == '0);
    assign row_last  = (row_idx_q == RW'(HEIGHT - 1));

    always_comb begin
        row_up_idx = row_idx_q - RW'(1);
        row_dn_idx = row_idx_q + RW'(1);
        row_mid    = cur_rows[row_idx_q];
`ifdef CONWARE_TORUS_EN
        if (row_first) row_up_idx = RW'(HEIGHT - 1);
        if (row_last)  row_dn_idx = '0;
        row_up = cur_rows[row_up_idx];
        row_dn = cur_rows[row_dn_idx];
`else
        row_up = row_first ? '0 : cur_rows[row_up_idx];
        row_dn = row_last  ? '0 : cur_rows[row_dn_idx];
`endif
    end

    // Rows padded by one cell on each side: ext[c+1] is column c, ext[0] is
    // the column left of 0 and ext[WIDTH+1] the column right of WIDTH-1.
    logic [WIDTH+1:0] up_ext;
    logic [WIDTH+1:0] mid_ext;
    logic [WIDTH+1:0] dn_ext;

`ifdef CONWARE_TORUS_EN
    assign up_ext  = {row_up[0],  row_up,  row_up[WIDTH-1]};
    assign mid_ext = {row_mid[0], row_mid, row_mid[WIDTH-1]};
    assign dn_ext  = {row_dn[0],  row_dn,  row_dn[WIDTH-1]};
`else
    assign up_ext  = {1'b0, row_up,  1'b0};
    assign mid_ext = {1'b0, row_mid, 1'b0};
    assign dn_ext  = {1'b0, row_dn,  1'b0};
`endif

    // ---------------------------------------------------------------------
    // Life rule, all columns of the row in parallel
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] new_row;

    for (genvar gc = 0; gc < WIDTH; gc++) begin : g_cells
        logic [3:0] nbr_cnt;

        assign nbr_cnt = 4'(up_ext[gc])  + 4'(up_ext[gc+1])  + 4'(up_ext[gc+2]) +
                         4'(mid_ext[gc])                     + 4'(mid_ext[gc+2]) +
                         4'(dn_ext[gc])  + 4'(dn_ext[gc+1])  + 4'(dn_ext[gc+2]);

        assign new_row[gc] = (nbr_cnt == 4'd3) | (mid_ext[gc+1] & (nbr_cnt == 4'd2));
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        nxt_d         = nxt_q;
        pix_idx_d     = pix_idx_q;
        out_idx_d     = out_idx_q;
        row_idx_d     = row_idx_q;
        gen_ctr_d     = gen_ctr_q;
        num_gens_d    = num_gens_q;
        frames_done_d = frames_done_q;
        frame_err_d   = frame_err_q;

        case (state_q)
            StLoad: begin
                if (s_beat) begin
                    cur_d[pix_idx_q] = (S_AXIS_TDATA != DEAD_COLOR);
                    pix_idx_d        = pix_idx_q + PW'(1);
                    if (S_AXIS_TLAST || pix_last) begin
                        num_gens_d = num_gens;
                        gen_ctr_d  = '0;
                        row_idx_d  = '0;
                        // Early TLAST or missing TLAST on the final pixel.
                        if (S_AXIS_TLAST != pix_last) frame_err_d = 1'b1;
                        state_d = (num_gens == 8'd0) ? StSend : StCompute;
                    end
                end
            end

            StCompute: begin
                for (int r = 0; r < HEIGHT; r++) begin
                    if (row_idx_q == RW'(r)) nxt_d[r*WIDTH +: WIDTH] = new_row;
                end
                row_idx_d = row_idx_q + RW'(1);
                if (row_last) begin
                    // cur stays frozen for the whole generation; swap in the
                    // finished board, including the row computed this cycle.
                    cur_d     = nxt_d;
                    row_idx_d = '0;
                    gen_ctr_d = gen_ctr_q + 8'd1;
                    if (gen_ctr_d == num_gens_q) state_d = StSend;
                end
            end

            StSend: begin
                if (m_beat) begin
                    out_idx_d = out_idx_q + PW'(1);
                    if (out_last) begin
                        frames_done_d = frames_done_q + 32'd1;
                        pix_idx_d     = '0;
                        out_idx_d     = '0;
                        gen_ctr_d     = '0;
                        // Clear so that cells of a short next frame read dead.
                        cur_d         = '0;
                        nxt_d         = '0;
                        state_d       = StLoad;
                    end
                end
            end

            default: state_d = StLoad;
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= StLoad;
            cur_q         <= '0;
            nxt_q         <= '0;
            pix_idx_q     <= '0;
            out_idx_q     <= '0;
            row_idx_q     <= '0;
            gen_ctr_q     <= '0;
            num_gens_q    <= '0;
            frames_done_q <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            nxt_q         <= nxt_d;
            pix_idx_q     <= pix_idx_d;
            out_idx_q     <= out_idx_d;
            row_idx_q     <= row_idx_d;
            gen_ctr_q     <= gen_ctr_d;
            num_gens_q    <= num_gens_d;
            frames_done_q <= frames_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign S_AXIS_TREADY = s_tready;
    assign M_AXIS_TVALID = m_tvalid;
    assign M_AXIS_TDATA  = m_tvalid ? (cur_q[out_idx_q] ? ALIVE_COLOR : DEAD_COLOR) : '0;
    assign M_AXIS_TLAST  = m_tvalid && out_last;
    assign M_AXIS_TKEEP  = '1;
    assign M_AXIS_TSTRB  = '1;
    assign state         = state_q;
    assign gen_ctr       = gen_ctr_q;
    assign frames_done   = frames_done_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_conware_grid.sv
// -----------------------------------------------------------------------------
// tb_conware_grid
//
// Self-checking bench for conware_grid on an 8x8 board. Expected boards come
// from a cell-by-cell Life model (or hand-written boards for known patterns).
// -----------------------------------------------------------------------------
module tb_conware_grid;

    localparam int DW   = 32;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;
    localparam logic [31:0] ALIVE = 32'hFFFFFFFF;
    localparam logic [31:0] DEAD  = 32'h00000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        areset;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic [3:0]  m_tkeep;
    logic [3:0]  m_tstrb;
    logic [7:0]  num_gens;
    logic [1:0]  state;
    logic [7:0]  gen_ctr;
    logic [31:0] frames_done;
    logic        frame_err;

    conware_grid #(
        .DWIDTH     (DW),
        .WIDTH      (W),
        .HEIGHT     (H),
        .ALIVE_COLOR(ALIVE),
        .DEAD_COLOR (DEAD)
    ) dut (
        .ACLK         (clk),
        .ARESET       (areset),
        .S_AXIS_TVALID(s_tvalid),
        .S_AXIS_TREADY(s_tready),
        .S_AXIS_TDATA (s_tdata),
        .S_AXIS_TLAST (s_tlast),
        .M_AXIS_TVALID(m_tvalid),
        .M_AXIS_TREADY(m_tready),
        .M_AXIS_TDATA (m_tdata),
        .M_AXIS_TLAST (m_tlast),
        .M_AXIS_TKEEP (m_tkeep),
        .M_AXIS_TSTRB (m_tstrb),
        .num_gens     (num_gens),
        .state        (state),
        .gen_ctr      (gen_ctr),
        .frames_done  (frames_done),
        .frame_err    (frame_err)
    );

    int   checks     = 0;
    int   errors     = 0;
    int   exp_frames = 0;
    logic exp_err    = 1'b0;

    bit in_board  [NPIX];
    bit exp_board [NPIX];
    bit mdl       [H][W];

    // One Life generation on mdl, straight from the rules.
    task automatic model_step();
        bit nb [H][W];
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0)) begin
`ifdef CONWARE_TORUS_EN
                            rr = (rr + H) % H;
                            cc = (cc + W) % W;
                            n += int'(mdl[rr][cc]);
`else
                            if (rr >= 0 && rr < H && cc >= 0 && cc < W) n += int'(mdl[rr][cc]);
`endif
                        end
                    end
                end
                nb[r][c] = mdl[r][c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        mdl = nb;
    endtask

    task automatic clear_boards();
        for (int p = 0; p < NPIX; p++) begin
            in_board[p]  = 1'b0;
            exp_board[p] = 1'b0;
        end
    endtask

    // Load in_board, wait for the result and check it beat by beat.
    // tlast_at >= NPIX means no TLAST is ever driven.
    // rmode: 0 always ready, 1 toggle 1-0, 2 random.
    task automatic run_frame(input string tag, input int ngens, input int tlast_at,
                             input int rmode, input bit gaps, input bit use_exp);
        int          n_in;
        int          i;
        int          lat;
        int          budget;
        int          beats;
        int          cyc;
        bit          rdy;
        bit          tog;
        bit          stalled;
        logic [31:0] held_d;
        logic        held_l;
        logic [31:0] exp_data;
        logic [1:0]  exp_state;

        n_in = (tlast_at < NPIX) ? tlast_at + 1 : NPIX;
        if (use_exp) begin
            for (int p = 0; p < NPIX; p++) mdl[p / W][p % W] = exp_board[p];
        end else begin
            for (int p = 0; p < NPIX; p++) mdl[p / W][p % W] = (p < n_in) ? in_board[p] : 1'b0;
            for (int g = 0; g < ngens; g++) model_step();
        end
        if (tlast_at != NPIX - 1) exp_err = 1'b1;

        num_gens = 8'(ngens);
        i = 0;
        while (i < n_in) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                s_tdata  = $urandom;
                s_tlast  = 1'($urandom_range(0, 1));
            end else begin
                s_tvalid = 1'b1;
                s_tdata  = in_board[i] ? ($urandom | 32'h1) : DEAD;
                s_tlast  = (i == tlast_at);
                i++;
            end
        end

        budget = 1 + ngens * H + 4;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                s_tvalid  = 1'b0;
                s_tlast   = 1'b0;
                num_gens  = 8'($urandom);
                exp_state = (ngens == 0) ? 2'd2 : 2'd1;
                checks++;
                if (state !== exp_state) begin
                    errors++;
                    $display("FAIL %s state_after_load: got %0d want %0d", tag, state, exp_state);
                end
                checks++;
                if (frame_err !== exp_err) begin
                    errors++;
                    $display("FAIL %s frame_err: got %b want %b", tag, frame_err, exp_err);
                end
            end
            if (m_tvalid || lat >= budget) break;
        end

        checks++;
        if (!m_tvalid || lat != 1 + ngens * H) begin
            errors++;
            $display("FAIL %s latency: got %0d (tvalid=%b) want %0d", tag, lat, m_tvalid,
                     1 + ngens * H);
            if (!m_tvalid) return;
        end
        checks++;
        if (gen_ctr !== 8'(ngens)) begin
            errors++;
            $display("FAIL %s gen_ctr: got %0d want %0d", tag, gen_ctr, ngens);
        end

        beats   = 0;
        cyc     = 0;
        tog     = 1'b1;
        stalled = 1'b0;
        held_d  = '0;
        held_l  = 1'b0;
        while (beats < NPIX && cyc < 400) begin
            if (stalled) begin
                checks++;
                if (m_tvalid !== 1'b1 || m_tdata !== held_d || m_tlast !== held_l) begin
                    errors++;
                    $display("FAIL %s stall_hold: valid=%b data=%h last=%b want valid=1 data=%h last=%b",
                             tag, m_tvalid, m_tdata, m_tlast, held_d, held_l);
                end
            end
            if (m_tvalid) begin
                exp_data = mdl[beats / W][beats % W] ? ALIVE : DEAD;
                checks++;
                if (m_tdata !== exp_data) begin
                    errors++;
                    $display("FAIL %s pixel[%0d]: got %h want %h", tag, beats, m_tdata, exp_data);
                end
                checks++;
                if (m_tlast !== (beats == NPIX - 1)) begin
                    errors++;
                    $display("FAIL %s tlast[%0d]: got %b want %b", tag, beats, m_tlast,
                             (beats == NPIX - 1));
                end
                checks++;
                if ({m_tkeep, m_tstrb} !== 8'hFF) begin
                    errors++;
                    $display("FAIL %s keep_strb[%0d]: got %h want ff", tag, beats,
                             {m_tkeep, m_tstrb});
                end
            end
            case (rmode)
                0:       rdy = 1'b1;
                1: begin
                    rdy = tog;
                    tog = !tog;
                end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            m_tready = rdy;
            stalled  = m_tvalid && !rdy;
            held_d   = m_tdata;
            held_l   = m_tlast;
            if (m_tvalid && rdy) beats++;
            if (beats < NPIX) begin
                @(negedge clk);
                cyc++;
            end
        end

        @(negedge clk);
        m_tready = 1'b0;
        exp_frames++;
        checks++;
        if (beats != NPIX || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s beat_count: got %0d beats, tvalid after=%b want %0d beats, tvalid=0",
                     tag, beats, m_tvalid, NPIX);
        end
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL %s state_after_send: got %0d want 0", tag, state);
        end
        checks++;
        if (frames_done !== 32'(exp_frames)) begin
            errors++;
            $display("FAIL %s frames_done: got %0d want %0d", tag, frames_done, exp_frames);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (s_tready !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: tready=%b tvalid=%b want 0 0", s_tready, m_tvalid);
        end
        areset = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", state);
        end
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tready: got %b want 1", s_tready);
        end
        checks++;
        if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mout: valid=%b last=%b data=%h want 0 0 0", m_tvalid, m_tlast,
                     m_tdata);
        end
        checks++;
        if (gen_ctr !== 8'd0 || frames_done !== 32'd0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: gen_ctr=%0d frames_done=%0d frame_err=%b want 0 0 0",
                     gen_ctr, frames_done, frame_err);
        end
        exp_frames = 0;
        exp_err    = 1'b0;
    endtask

    task automatic test_blinker();
        clear_boards();
        in_board[3*W + 2] = 1'b1;
        in_board[3*W + 3] = 1'b1;
        in_board[3*W + 4] = 1'b1;
        exp_board[2*W + 3] = 1'b1;
        exp_board[3*W + 3] = 1'b1;
        exp_board[4*W + 3] = 1'b1;
        run_frame("blinker_g1", 1, NPIX - 1, 0, 1'b0, 1'b1);
        for (int p = 0; p < NPIX; p++) exp_board[p] = in_board[p];
        run_frame("blinker_g2", 2, NPIX - 1, 0, 1'b0, 1'b1);
        run_frame("blinker_g0", 0, NPIX - 1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_glider();
        clear_boards();
        in_board[5*W + 6] = 1'b1;
        in_board[6*W + 7] = 1'b1;
        in_board[7*W + 5] = 1'b1;
        in_board[7*W + 6] = 1'b1;
        in_board[7*W + 7] = 1'b1;
`ifdef CONWARE_TORUS_EN
        exp_board[6*W + 7] = 1'b1;
        exp_board[7*W + 0] = 1'b1;
        exp_board[0*W + 6] = 1'b1;
        exp_board[0*W + 7] = 1'b1;
        exp_board[0*W + 0] = 1'b1;
`else
        exp_board[6*W + 6] = 1'b1;
        exp_board[6*W + 7] = 1'b1;
        exp_board[7*W + 6] = 1'b1;
        exp_board[7*W + 7] = 1'b1;
`endif
        run_frame("glider_g4", 4, NPIX - 1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            for (int p = 0; p < NPIX; p++) in_board[p] = ($urandom_range(0, 2) == 0);
            run_frame("random", $urandom_range(0, 3), NPIX - 1, 2, 1'b1, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        for (int p = 0; p < NPIX; p++) in_board[p] = ($urandom_range(0, 1) == 0);
        run_frame("toggle_ready", 2, NPIX - 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_early_tlast();
        for (int p = 0; p < NPIX; p++) in_board[p] = ($urandom_range(0, 1) == 0);
        run_frame("early_tlast", 1, 9, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_compute();
        for (int p = 0; p < NPIX; p++) in_board[p] = ($urandom_range(0, 1) == 0);
        num_gens = 8'd5;
        for (int p = 0; p < NPIX; p++) begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = in_board[p] ? ALIVE : DEAD;
            s_tlast  = (p == NPIX - 1);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL midreset_pre_state: got %0d want 1", state);
        end
        areset = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: state=%0d tvalid=%b tready=%b want 0 0 0", state,
                     m_tvalid, s_tready);
        end
        checks++;
        if (gen_ctr !== 8'd0 || frames_done !== 32'd0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_status: gen_ctr=%0d frames_done=%0d frame_err=%b want 0 0 0",
                     gen_ctr, frames_done, frame_err);
        end
        areset     = 1'b0;
        exp_frames = 0;
        exp_err    = 1'b0;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_tready: got %b want 1", s_tready);
        end
        // Short frame: unloaded cells must come out dead after the reset.
        for (int p = 0; p < NPIX; p++) in_board[p] = 1'b1;
        run_frame("post_reset_short", 0, 9, 0, 1'b0, 1'b0);
        for (int p = 0; p < NPIX; p++) in_board[p] = ($urandom_range(0, 2) == 0);
        run_frame("post_reset_full", 2, NPIX - 1, 2, 1'b1, 1'b0);
        for (int p = 0; p < NPIX; p++) in_board[p] = ($urandom_range(0, 2) == 0);
        run_frame("missing_tlast", 1, NPIX, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        num_gens = 8'd0;

        test_reset();
        test_blinker();
        test_glider();
        test_random();
        test_backpressure();
        test_early_tlast();
        test_reset_mid_compute();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
